// File: rtl/cdb_rr_arbiter_if.sv
// Request/grant bundle between the functional units and the CDB arbiter.
// With CDB_ARB_PERF_EN defined the bundle also carries the conflict counter.
interface cdb_rr_arbiter_if #(
  parameter int NUM_FU = 3
);
  localparam int IDXW = $clog2(NUM_FU);

  logic [NUM_FU-1:0] cdb_req;
  logic              flush;
  logic [NUM_FU-1:0] fu_sel;
  logic              grant_valid;
  logic [IDXW-1:0]   grant_idx;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]       conflict_cnt;

  modport master (output cdb_req, flush, input fu_sel, grant_valid, grant_idx, conflict_cnt);
  modport slave  (input cdb_req, flush, output fu_sel, grant_valid, grant_idx, conflict_cnt);
`else
  modport master (output cdb_req, flush, input fu_sel, grant_valid, grant_idx);
  modport slave  (input cdb_req, flush, output fu_sel, grant_valid, grant_idx);
`endif
endinterface

// File: rtl/cdb_rr_arbiter.sv
// CDB writeback arbiter: starvation guard > fixed-priority class > round-robin.
// Optional conflict counter enabled by CDB_ARB_PERF_EN.
module cdb_rr_arbiter #(
  parameter int              NUM_FU    = 3,
  parameter logic [NUM_FU-1:0] PRIO_MASK = 3'b100,
  parameter int              MAX_WAIT  = 4
) (
  input logic              clk,
  input logic              rst_n,
  cdb_rr_arbiter_if.slave  arb
);
  localparam int IDXW = $clog2(NUM_FU);
  localparam int WW   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [NUM_FU-1:0] r_fu_sel;
  logic              r_grant_valid;
  logic [IDXW-1:0]   r_grant_idx;
  logic [IDXW-1:0]   r_last_rr;

  logic [WW-1:0]     w_wait [NUM_FU];
  logic [NUM_FU-1:0] w_starved;
  logic [NUM_FU-1:0] w_sel;
  logic [IDXW-1:0]   w_idx;
  logic              w_found;
  logic              w_from_rr;

  // Position k steps after 'last' in round-robin order, k in 1..NUM_FU.
  function automatic logic [IDXW-1:0] rr_pos(input logic [IDXW-1:0] last, input int k);
    int s;
    s = int'(last) + k;
    if (s >= NUM_FU) s = s - NUM_FU;
    return IDXW'(s);
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_unit
      if (PRIO_MASK[gi]) begin : g_prio
        assign w_wait[gi]    = '0;
        assign w_starved[gi] = 1'b0;
      end else begin : g_rr
        logic [WW-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_cnt <= '0;
          end else if (arb.flush || !arb.cdb_req[gi] || w_sel[gi]) begin
            r_cnt <= '0;
          end else if (r_cnt != WW'(MAX_WAIT)) begin
            r_cnt <= r_cnt + WW'(1);
          end
        end
        assign w_wait[gi]    = r_cnt;
        assign w_starved[gi] = (MAX_WAIT > 0) && arb.cdb_req[gi] && (r_cnt == WW'(MAX_WAIT));
      end
    end
  endgenerate

  always_comb begin
    logic [IDXW-1:0] p;
    w_sel     = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    w_from_rr = 1'b0;
    p         = '0;
    for (int k = 1; k <= NUM_FU; k++) begin
      p = rr_pos(r_last_rr, k);
      if (!w_found && w_starved[p]) begin
        w_found   = 1'b1;
        w_from_rr = 1'b1;
        w_idx     = p;
      end
    end
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (!w_found && PRIO_MASK[i] && arb.cdb_req[i]) begin
        w_found = 1'b1;
        w_idx   = IDXW'(i);
      end
    end
    for (int k = 1; k <= NUM_FU; k++) begin
      p = rr_pos(r_last_rr, k);
      if (!w_found && !PRIO_MASK[p] && arb.cdb_req[p]) begin
        w_found   = 1'b1;
        w_from_rr = 1'b1;
        w_idx     = p;
      end
    end
    if (w_found) w_sel[w_idx] = 1'b1;
  end

  // A flush kills the grant but keeps the RR pointer so fairness survives mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fu_sel      <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_last_rr     <= IDXW'(NUM_FU - 1);
    end else if (arb.flush) begin
      r_fu_sel      <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
    end else begin
      r_fu_sel      <= w_sel;
      r_grant_valid <= w_found;
      r_grant_idx   <= w_found ? w_idx : '0;
      if (w_from_rr) r_last_rr <= w_idx;
    end
  end

  assign arb.fu_sel      = r_fu_sel;
  assign arb.grant_valid = r_grant_valid;
  assign arb.grant_idx   = r_grant_idx;

`ifdef CDB_ARB_PERF_EN
  logic [31:0] r_conflict_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (arb.flush) begin
      r_conflict_cnt <= '0;
    end else if ($countones(arb.cdb_req) > 1) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end
  assign arb.conflict_cnt = r_conflict_cnt;
`endif
endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Scoreboard bench for cdb_rr_arbiter (NUM_FU=4, PRIO_MASK=4'b1000, MAX_WAIT=3).
// Directed scenarios followed by randomized traffic against a queue-based model.
module tb_cdb_rr_arbiter;
  localparam int NFU  = 4;
  localparam int MAXW = 3;

  typedef struct {
    logic [3:0] sel;
    logic [1:0] idx;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_rr_arbiter_if #(.NUM_FU(NFU)) bus ();

  cdb_rr_arbiter #(
    .NUM_FU   (NFU),
    .PRIO_MASK(4'b1000),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .arb  (bus)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  bit [3:0] pm = 4'b1000;
  int       m_last;
  int       m_wait [NFU];

  // Reference model: rules applied directly on integer state.
  function automatic int model_pick(input logic [3:0] req, output bit rr_grant);
    int order[$];
    int g;
    g = -1;
    rr_grant = 1'b0;
    for (int k = 1; k <= NFU; k++) order.push_back((m_last + k) % NFU);
    foreach (order[j])
      if (g < 0 && !pm[order[j]] && req[order[j]] && m_wait[order[j]] == MAXW) begin
        g = order[j];
        rr_grant = 1'b1;
      end
    for (int i = NFU - 1; i >= 0; i--)
      if (g < 0 && pm[i] && req[i]) g = i;
    foreach (order[j])
      if (g < 0 && !pm[order[j]] && req[order[j]]) begin
        g = order[j];
        rr_grant = 1'b1;
      end
    return g;
  endfunction

  function automatic int model_step(input logic [3:0] req, input logic fl);
    int g;
    bit rr;
    if (fl) begin
      foreach (m_wait[i]) m_wait[i] = 0;
      return -1;
    end
    g = model_pick(req, rr);
    for (int i = 0; i < NFU; i++) begin
      if (pm[i] || !req[i] || i == g) m_wait[i] = 0;
      else if (m_wait[i] < MAXW) m_wait[i] = m_wait[i] + 1;
    end
    if (rr) m_last = g;
    return g;
  endfunction

  function automatic exp_t from_idx(input int g);
    exp_t e;
    e.sel = '0;
    e.idx = '0;
    e.v   = 1'b0;
    if (g >= 0) begin
      e.sel[g] = 1'b1;
      e.idx    = 2'(g);
      e.v      = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t from_sel(input logic [3:0] s);
    int g;
    g = -1;
    for (int i = 0; i < NFU; i++) if (s[i]) g = i;
    return from_idx(g);
  endfunction

  // Drive one cycle of stimulus; optional fixed expectation from the scenario list.
  task automatic apply(input logic [3:0] req, input logic fl, input bit fixed, input logic [3:0] fsel);
    int g;
    @(negedge clk);
    bus.cdb_req = req;
    bus.flush   = fl;
    g = model_step(req, fl);
    if (fixed) exp_q.push_back(from_sel(fsel));
    else       exp_q.push_back(from_idx(g));
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (bus.fu_sel !== 4'b0 || bus.grant_valid !== 1'b0 || bus.grant_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL %s fu_sel=%b valid=%b idx=%0d required 0000/0/0",
               name, bus.fu_sel, bus.grant_valid, bus.grant_idx);
    end else begin
      $display("ok   %s fu_sel=%b valid=%b idx=%0d", name, bus.fu_sel, bus.grant_valid, bus.grant_idx);
    end
  endtask

  task automatic do_reset();
    mon_en      = 1'b0;
    bus.cdb_req = '0;
    bus.flush   = 1'b0;
    rst_n       = 1'b0;
    exp_q.delete();
    m_last = NFU - 1;
    foreach (m_wait[i]) m_wait[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("reset");
    mon_en = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (bus.fu_sel !== e.sel || bus.grant_valid !== e.v || bus.grant_idx !== e.idx) begin
        miscompares++;
        $display("FAIL grant cyc=%0d fu_sel=%b valid=%b idx=%0d required %b/%b/%0d",
                 cyc, bus.fu_sel, bus.grant_valid, bus.grant_idx, e.sel, e.v, e.idx);
      end else begin
        $display("ok   grant cyc=%0d fu_sel=%b valid=%b idx=%0d", cyc, bus.fu_sel, bus.grant_valid, bus.grant_idx);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] req;
    logic       fl;
    bus.cdb_req = '0;
    bus.flush   = 1'b0;

    // Single request then idle.
    do_reset();
    apply(4'b0001, 1'b0, 1'b1, 4'b0001);
    apply(4'b0000, 1'b0, 1'b1, 4'b0000);

    // Round-robin rotation over three ALUs.
    do_reset();
    apply(4'b0111, 1'b0, 1'b1, 4'b0001);
    apply(4'b0111, 1'b0, 1'b1, 4'b0010);
    apply(4'b0111, 1'b0, 1'b1, 4'b0100);
    apply(4'b0111, 1'b0, 1'b1, 4'b0001);
    apply(4'b0111, 1'b0, 1'b1, 4'b0010);
    apply(4'b0111, 1'b0, 1'b1, 4'b0100);

    // Priority unit wins until unit0 starves.
    do_reset();
    apply(4'b1001, 1'b0, 1'b1, 4'b1000);
    apply(4'b1001, 1'b0, 1'b1, 4'b1000);
    apply(4'b1001, 1'b0, 1'b1, 4'b1000);
    apply(4'b1001, 1'b0, 1'b1, 4'b0001);
    apply(4'b1001, 1'b0, 1'b1, 4'b1000);

    // Flush overrides requests; pointer retained from reset.
    do_reset();
    apply(4'b0110, 1'b1, 1'b1, 4'b0000);
    apply(4'b0110, 1'b0, 1'b1, 4'b0010);

    // Asynchronous reset mid-cycle while a grant is held.
    do_reset();
    apply(4'b0100, 1'b0, 1'b1, 4'b0100);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_idle("async_reset");

`ifdef CDB_ARB_PERF_EN
    do_reset();
    repeat (5) apply(4'b0011, 1'b0, 1'b0, 4'b0000);
    repeat (2) apply(4'b0001, 1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    #2;
    vectors++;
    if (bus.conflict_cnt !== 32'd5) begin
      miscompares++;
      $display("FAIL conflict_cnt=%0d required 5", bus.conflict_cnt);
    end else $display("ok   conflict_cnt=%0d", bus.conflict_cnt);
    apply(4'b0000, 1'b1, 1'b0, 4'b0000);
    @(posedge clk);
    #2;
    vectors++;
    if (bus.conflict_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL conflict_cnt_flush=%0d required 0", bus.conflict_cnt);
    end else $display("ok   conflict_cnt_flush=%0d", bus.conflict_cnt);
`endif

    // Randomized traffic: requests often held to exercise starvation, occasional flush.
    do_reset();
    req = '0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 4) req = 4'($urandom_range(0, 15));
      fl = ($urandom_range(0, 11) == 0);
      apply(req, fl, 1'b0, 4'b0000);
    end
    apply(4'b0000, 1'b0, 1'b0, 4'b0000);
    repeat (3) @(negedge clk);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
